// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 single-bit mux.
// Ownership is bounded by MAX_HOLD cycles whenever another requester is waiting.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] I,
    output logic [1:0] S,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       Y
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       s_nxt;
    logic [3:0]       gnt_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       winner;
    logic             any_req;
    logic             contention;

    // First set request at or after the pointer, wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // While granted, ptr == owner+1, so the owner sits last in the search
    // order and only wins if nobody else requests.
    assign winner     = pick(req, ptr);
    assign any_req    = |req;
    assign contention = |(req & ~gnt);

    always_comb begin
        state_nxt    = state;
        s_nxt        = S;
        gnt_nxt      = gnt;
        busy_nxt     = busy;
        hold_cnt_nxt = hold_cnt;
        ptr_nxt      = ptr;

        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt    = ST_GRANT;
                    s_nxt        = winner;
                    gnt_nxt      = 4'b0001 << winner;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = '0;
                    ptr_nxt      = winner + 2'd1;
                end
            end
            ST_GRANT: begin
                if (!req[S]) begin
                    if (any_req) begin
                        s_nxt        = winner;
                        gnt_nxt      = 4'b0001 << winner;
                        busy_nxt     = 1'b1;
                        hold_cnt_nxt = '0;
                        ptr_nxt      = winner + 2'd1;
                    end else begin
                        state_nxt    = ST_IDLE;
                        gnt_nxt      = 4'b0000;
                        busy_nxt     = 1'b0;
                        hold_cnt_nxt = '0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_cnt_nxt = '0;
                    if (contention) begin
                        s_nxt   = winner;
                        gnt_nxt = 4'b0001 << winner;
                        ptr_nxt = winner + 2'd1;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            S        <= 2'b00;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'd0;
        end else begin
            state    <= state_nxt;
            S        <= s_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            hold_cnt <= hold_cnt_nxt;
            ptr      <= ptr_nxt;
        end
    end

    // Data path is purely combinational from the registered select.
    assign Y = busy ? I[S] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: default instance plus a MAX_HOLD=1 instance.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req, req1;
    logic [3:0] I, I1;
    logic [1:0] S, S1;
    logic [3:0] gnt, gnt1;
    logic       busy, busy1;
    logic       Y, Y1;

    int checks;
    int errors;

    rr_mux_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .I(I),
        .S(S), .gnt(gnt), .busy(busy), .Y(Y)
    );

    rr_mux_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .I(I1),
        .S(S1), .gnt(gnt1), .busy(busy1), .Y(Y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b0000; I = 4'b1111; req1 = 4'b0000; I1 = 4'b1111;
        do_reset();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b00, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: S=%b gnt=%b busy=%b Y=%b, expected S=00 gnt=0000 busy=0 Y=0", S, gnt, busy, Y);
        end
        checks++;
        if ({S1, gnt1, busy1, Y1} !== {2'b00, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mh1: S=%b gnt=%b busy=%b Y=%b, expected S=00 gnt=0000 busy=0 Y=0", S1, gnt1, busy1, Y1);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 4'b0100; I = 4'b1010;
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b10, 4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: S=%b gnt=%b busy=%b Y=%b, expected S=10 gnt=0100 busy=1 Y=0", S, gnt, busy, Y);
        end
        I = 4'b0100;
        #1;
        checks++;
        if (Y !== 1'b1) begin
            errors++;
            $display("FAIL single_comb_y: Y=%b, expected 1", Y);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b10, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_release: S=%b gnt=%b busy=%b Y=%b, expected S=10 gnt=0000 busy=0 Y=0", S, gnt, busy, Y);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_s;
        logic [3:0] exp_g;
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        tick();
        for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 8; k++) begin
                I     = 4'(k * 5 + o * 3);
                #1;
                exp_s = 2'(o % 4);
                exp_g = 4'b0001 << (o % 4);
                checks++;
                if ({S, gnt, busy, Y} !== {exp_s, exp_g, 1'b1, I[o % 4]}) begin
                    errors++;
                    $display("FAIL rotation o=%0d k=%0d: S=%b gnt=%b busy=%b Y=%b, expected S=%b gnt=%b busy=1 Y=%b",
                             o, k, S, gnt, busy, Y, exp_s, exp_g, I[o % 4]);
                end
                tick();
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_release_handoff();
        do_reset();
        I   = 4'b1000;
        req = 4'b0010;
        tick();
        req = 4'b1011;
        tick();
        tick();
        checks++;
        if ({S, gnt, busy} !== {2'b01, 4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL handoff_pre: S=%b gnt=%b busy=%b, expected S=01 gnt=0010 busy=1", S, gnt, busy);
        end
        req = 4'b1001;
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b11, 4'b1000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL handoff_edge: S=%b gnt=%b busy=%b Y=%b, expected S=11 gnt=1000 busy=1 Y=1", S, gnt, busy, Y);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if ({S, gnt, busy} !== {2'b11, 4'b1000, 1'b1}) begin
                errors++;
                $display("FAIL handoff_hold k=%0d: S=%b gnt=%b busy=%b, expected S=11 gnt=1000 busy=1", k, S, gnt, busy);
            end
        end
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b00, 4'b0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL handoff_limit: S=%b gnt=%b busy=%b Y=%b, expected S=00 gnt=0001 busy=1 Y=0", S, gnt, busy, Y);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_hold_no_contention();
        do_reset();
        I   = 4'b0100;
        req = 4'b0100;
        tick();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({S, gnt, busy, Y} !== {2'b10, 4'b0100, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL hold_solo k=%0d: S=%b gnt=%b busy=%b Y=%b, expected S=10 gnt=0100 busy=1 Y=1", k, S, gnt, busy, Y);
            end
            tick();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        I   = 4'b1001;
        req = 4'b1000;
        tick();
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b11, 4'b1000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midreset_pre: S=%b gnt=%b busy=%b Y=%b, expected S=11 gnt=1000 busy=1 Y=1", S, gnt, busy, Y);
        end
        rst_n = 1'b0;
        req   = 4'b1001;
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b00, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_edge: S=%b gnt=%b busy=%b Y=%b, expected S=00 gnt=0000 busy=0 Y=0", S, gnt, busy, Y);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({S, gnt, busy, Y} !== {2'b00, 4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midreset_first: S=%b gnt=%b busy=%b Y=%b, expected S=00 gnt=0001 busy=1 Y=1", S, gnt, busy, Y);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_g;
        logic       exp_y;
        do_reset();
        req1 = 4'b0011;
        I1   = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_y = (k % 2 == 0);
            checks++;
            if ({gnt1, busy1, Y1} !== {exp_g, 1'b1, exp_y}) begin
                errors++;
                $display("FAIL mh1_alternate k=%0d: gnt=%b busy=%b Y=%b, expected gnt=%b busy=1 Y=%b", k, gnt1, busy1, Y1, exp_g, exp_y);
            end
        end
        req1 = 4'b0000;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        I      = 4'b0000;
        req1   = 4'b0000;
        I1     = 4'b0000;
        test_reset();
        test_single_grant();
        test_rotation();
        test_release_handoff();
        test_hold_no_contention();
        test_reset_mid_grant();
        test_max_hold_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
